// File: rtl/videocard_core_pkg.sv
// Shared definitions for the video card core: opcodes, command address and status layout.
package videocard_core_pkg;

    typedef enum logic [2:0] {
        OP_NOP    = 3'd0,
        OP_CLEAR  = 3'd1,
        OP_INVERT = 3'd2,
        OP_INC    = 3'd3,
        OP_DOUBLE = 3'd4,
        OP_HALVE  = 3'd5
    } op_e;

    typedef enum logic {
        StIdle,
        StSweep
    } state_e;

    localparam logic [22:0] CMD_ADDR_DEFAULT = 23'h7FFFFE;

    localparam int unsigned STAT_BUSY_BIT = 7;
    localparam int unsigned STAT_OP_MSB   = 2;
    localparam int unsigned STAT_OP_LSB   = 0;

endpackage

// File: rtl/videocard_bus_if.sv
// Host-side control signals of the video card: write strobe and byte address.
interface videocard_bus_if #(
    parameter int unsigned ADDRESS_WIDTH = 23
) ();
    logic                     wren;
    logic [ADDRESS_WIDTH-1:0] adress;

    modport master (output wren, output adress);
    modport slave  (input  wren, input  adress);
endinterface

// File: rtl/videocard_alu_lane.sv
// One engine lane: applies the latched opcode to a single memory word.
module videocard_alu_lane
    import videocard_core_pkg::*;
#(
    parameter int unsigned CORE_WIDTH = 16
) (
    input  logic [CORE_WIDTH-1:0] i_word,
    input  logic [2:0]            i_op,
    output logic [CORE_WIDTH-1:0] o_result
);

    always_comb begin
        o_result = i_word;
        case (i_op)
            OP_CLEAR:  o_result = '0;
            OP_INVERT: o_result = ~i_word;
            OP_INC:    o_result = i_word + CORE_WIDTH'(1);
            OP_DOUBLE: o_result = {i_word[CORE_WIDTH-2:0], 1'b0};
            OP_HALVE:  o_result = {1'b0, i_word[CORE_WIDTH-1:1]};
            default:   o_result = i_word;
        endcase
    end

endmodule

// File: rtl/videocard_core.sv
// Byte-addressed 16-bit video memory with a command register that sweeps an ALU op over all words.
module videocard_core
    import videocard_core_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned ADDRESS_WIDTH = 23,
    parameter int unsigned CORE_WIDTH    = 16,
    parameter int unsigned MEM_WORDS     = 1024,
    parameter int unsigned NUM_CORES     = 16,
    parameter logic [ADDRESS_WIDTH-1:0] CMD_ADDR = CMD_ADDR_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    videocard_bus_if.slave        bus,
    inout  wire  [DATA_WIDTH-1:0] data
);

    localparam int unsigned IDX_W = $clog2(MEM_WORDS);
    localparam int unsigned ROWS  = MEM_WORDS / NUM_CORES;
    localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [ADDRESS_WIDTH-1:0] MEM_BYTES = ADDRESS_WIDTH'(2 * MEM_WORDS);

    logic [CORE_WIDTH-1:0] r_mem [MEM_WORDS];
    state_e                r_state;
    state_e                w_state_next;
    logic [ROW_W-1:0]      r_row;
    logic [2:0]            r_op;
    logic [DATA_WIDTH-1:0] r_rd;

    logic                  w_busy;
    logic                  w_last_row;
    logic                  w_in_mem;
    logic                  w_is_cmd;
    logic                  w_cmd_start;
    logic [IDX_W-1:0]      w_word_idx;
    logic [DATA_WIDTH-1:0] w_status;
    logic [DATA_WIDTH-1:0] w_rd_next;
    logic [IDX_W-1:0]      w_lane_idx [NUM_CORES];
    logic [CORE_WIDTH-1:0] w_lane_out [NUM_CORES];

    assign w_in_mem    = bus.adress < MEM_BYTES;
    assign w_is_cmd    = bus.adress == CMD_ADDR;
    assign w_word_idx  = bus.adress[IDX_W:1];
    assign w_last_row  = r_row == ROW_W'(ROWS - 1);
    assign w_cmd_start = bus.wren && w_is_cmd && !w_busy && (data[2:0] != OP_NOP);

    // Bus is released combinationally so turnaround costs no cycle.
    assign data = bus.wren ? 'z : r_rd;

    for (genvar g = 0; g < NUM_CORES; g++) begin : g_lane
        assign w_lane_idx[g] = IDX_W'(r_row * NUM_CORES + g);
        videocard_alu_lane #(
            .CORE_WIDTH (CORE_WIDTH)
        ) u_lane (
            .i_word   (r_mem[w_lane_idx[g]]),
            .i_op     (r_op),
            .o_result (w_lane_out[g])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= StIdle;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (w_cmd_start) w_state_next = StSweep;
            StSweep: if (w_last_row)  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        w_busy = (r_state == StSweep);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_row <= '0;
            r_op  <= '0;
        end else if (w_cmd_start) begin
            r_op  <= data[2:0];
            r_row <= '0;
        end else if (w_busy) begin
            r_row <= w_last_row ? '0 : r_row + ROW_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MEM_WORDS; i++) r_mem[i] <= '0;
        end else if (w_busy) begin
            for (int g = 0; g < NUM_CORES; g++) r_mem[w_lane_idx[g]] <= w_lane_out[g];
        end else if (bus.wren && w_in_mem) begin
            if (bus.adress[0]) r_mem[w_word_idx][2*DATA_WIDTH-1:DATA_WIDTH] <= data;
            else               r_mem[w_word_idx][DATA_WIDTH-1:0]            <= data;
        end
    end

    always_comb begin
        w_status                          = '0;
        w_status[STAT_BUSY_BIT]           = w_busy;
        w_status[STAT_OP_MSB:STAT_OP_LSB] = r_op;
    end

    always_comb begin
        w_rd_next = '0;
        if (w_in_mem) begin
            w_rd_next = bus.adress[0] ? r_mem[w_word_idx][2*DATA_WIDTH-1:DATA_WIDTH]
                                      : r_mem[w_word_idx][DATA_WIDTH-1:0];
        end else if (w_is_cmd) begin
            w_rd_next = w_status;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)          r_rd <= '0;
        else if (!bus.wren) r_rd <= w_rd_next;
    end

endmodule

// File: tb/tb_videocard_core.sv
// Directed bench for videocard_core: read expectations queued at issue, compared when data returns.
module tb_videocard_core;

    localparam logic [22:0] CMD = 23'h7FFFFE;

    logic       clk;
    logic       reset;
    logic       tb_oe;
    logic [7:0] tb_val;
    wire  [7:0] data;

    int checks   = 0;
    int failures = 0;

    logic [7:0] sb_exp [$];
    string      sb_tag [$];

    videocard_bus_if #(.ADDRESS_WIDTH(23)) bus ();

    videocard_core dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .data  (data)
    );

    assign data = tb_oe ? tb_val : 'z;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic wr(input logic [22:0] a, input logic [7:0] v);
        @(negedge clk);
        bus.wren   = 1'b1;
        bus.adress = a;
        tb_oe      = 1'b1;
        tb_val     = v;
    endtask

    task automatic rd(input logic [22:0] a, input logic [7:0] e, input string tag);
        logic [7:0] exp_v;
        string      exp_t;
        @(negedge clk);
        bus.wren   = 1'b0;
        bus.adress = a;
        tb_oe      = 1'b0;
        sb_exp.push_back(e);
        sb_tag.push_back(tag);
        @(posedge clk);
        #1;
        exp_v = sb_exp.pop_front();
        exp_t = sb_tag.pop_front();
        checks++;
        assert (data === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%02h expected=%02h", exp_t, data, exp_v);
        end
    endtask

    task automatic chk_bus(input logic [7:0] e, input string tag);
        checks++;
        assert (data === e) else begin
            failures++;
            $error("FAIL %s observed=%02h expected=%02h", tag, data, e);
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        bus.wren = 1'b0;
        tb_oe    = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    initial begin
        reset      = 1'b1;
        bus.wren   = 1'b0;
        bus.adress = '0;
        tb_oe      = 1'b0;
        tb_val     = '0;
        #12;
        chk_bus(8'h00, "reset_rd_reg");
        @(negedge clk);
        reset = 1'b0;
        rd(CMD, 8'h00, "reset_status");
        rd(23'd0, 8'h00, "reset_mem");

        // Fill: even byte = (2k)%128, odd byte = 0
        for (int k = 0; k < 640; k++) begin
            wr(23'(2 * k), 8'((2 * k) % 128));
            wr(23'(2 * k + 1), 8'h00);
        end
        rd(23'd2, 8'h02, "fill_w1_lo");
        rd(23'd3, 8'h00, "fill_w1_hi");
        rd(23'd128, 8'h00, "fill_w64_lo");
        rd(23'd127, 8'h00, "fill_w63_hi");
        rd(23'd126, 8'h7E, "fill_w63_lo");
        // Read register holds 0x7E; a host drive must appear unaltered on the bus
        @(negedge clk);
        bus.wren   = 1'b1;
        bus.adress = 23'd3000;
        tb_oe      = 1'b1;
        tb_val     = 8'h81;
        #1;
        chk_bus(8'h81, "bus_release");

        // DOUBLE sweep with busy boundary
        wr(CMD, 8'h04);
        rd(CMD, 8'h84, "dbl_busy_start");
        repeat (62) @(posedge clk);
        rd(CMD, 8'h84, "dbl_busy_last");
        rd(CMD, 8'h04, "dbl_done");
        rd(23'd2, 8'h04, "dbl_w1_lo");
        rd(23'd126, 8'hFC, "dbl_w63_lo");
        rd(23'd127, 8'h00, "dbl_w63_hi");
        rd(23'd1400, 8'h00, "dbl_w700_lo");

        // Byte-lane isolation
        wr(23'd10, 8'hAB);
        wr(23'd11, 8'hCD);
        rd(23'd10, 8'hAB, "lane_w5_lo");
        rd(23'd11, 8'hCD, "lane_w5_hi");
        wr(23'd10, 8'h12);
        rd(23'd10, 8'h12, "lane_w5_lo2");
        rd(23'd11, 8'hCD, "lane_w5_hi2");

        // Busy lockout: CLEAR, then INVERT with writes issued mid-sweep
        wr(CMD, 8'h01);
        idle(70);
        rd(23'd11, 8'h00, "clear_w5_hi");
        wr(CMD, 8'h02);
        wr(23'd0, 8'h55);
        wr(23'd1000, 8'h55);
        wr(CMD, 8'h03);
        idle(70);
        rd(23'd0, 8'hFF, "lock_w0_lo");
        rd(23'd1, 8'hFF, "lock_w0_hi");
        rd(23'd1000, 8'hFF, "lock_w500_lo");
        rd(CMD, 8'h02, "lock_opcode");
        wr(CMD, 8'h00);
        rd(CMD, 8'h02, "nop_no_start");

        // Out-of-range write/read, INCREMENT wrap, HALVE
        wr(23'd2048, 8'h77);
        rd(23'd2048, 8'h00, "oor_read");
        rd(23'd2047, 8'hFF, "oor_neighbour");
        wr(CMD, 8'h03);
        idle(70);
        rd(23'd0, 8'h00, "inc_wrap_lo");
        rd(23'd1, 8'h00, "inc_wrap_hi");
        rd(23'd2047, 8'h00, "inc_wrap_last");
        wr(23'd2, 8'h01);
        wr(23'd3, 8'h80);
        wr(CMD, 8'h05);
        idle(70);
        rd(23'd2, 8'h00, "halve_lo");
        rd(23'd3, 8'h40, "halve_hi");
        rd(CMD, 8'h05, "halve_status");

        // Opcode 6 still holds busy for the sweep but leaves data alone
        wr(CMD, 8'h06);
        rd(CMD, 8'h86, "op6_busy");
        idle(70);
        rd(CMD, 8'h06, "op6_done");
        rd(23'd3, 8'h40, "op6_w1_hi");

        // Async reset mid-sweep
        wr(23'd4, 8'h33);
        wr(CMD, 8'h02);
        rd(CMD, 8'h82, "pre_reset_busy");
        repeat (8) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk_bus(8'h00, "async_rd_clear");
        @(negedge clk);
        reset = 1'b0;
        rd(CMD, 8'h00, "post_reset_status");
        rd(23'd4, 8'h00, "post_reset_w2");
        rd(23'd3, 8'h00, "post_reset_w1");
        rd(23'd2047, 8'h00, "post_reset_w1023");
        rd(CMD, 8'h00, "post_reset_idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/videocard_core.md
Name: videocard_core

Overview:
- Byte-addressed video memory with a bulk-processing engine.
- A host drives an 8-bit bidirectional data bus and a 23-bit byte address. The block stores 16-bit words: even byte address = LS byte, odd byte address = MS byte.
- A command register at a fixed top address starts a parallel "core" engine. The engine applies one operation to every stored word, NUM_CORES words per clock.

Parameters:
- DATA_WIDTH, 8, host data bus width.
- ADDRESS_WIDTH, 23, host byte-address width.
- CORE_WIDTH, 16, memory word / core datapath width.
- MEM_WORDS, 1024, number of 16-bit words; must be a multiple of NUM_CORES.
- NUM_CORES, 16, words processed per clock by the engine.
- CMD_ADDR, 23'h7FFFFE, command/status register byte address.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- wren  in  1  1 = host writes (bus driven by host); 0 = host reads (bus driven by block).
- adress  in  ADDRESS_WIDTH  host byte address.
- data  inout  DATA_WIDTH  bidirectional bus; block drives only when wren=0, otherwise high-Z.

Behaviour:
- Reset (asynchronous, active-high): all memory words 0, cmd=0, busy=0, row counter=0, read register=0x00.
- Address decode:
  - Memory region: adress < 2*MEM_WORDS, word index = adress>>1, byte select = adress[0].
  - adress == CMD_ADDR: command/status register.
  - Any other address: writes ignored, reads return 0x00.
- Host write: on a rising edge with wren=1, the addressed byte of the addressed word is updated; the other byte is unchanged.
  - Memory writes are ignored while busy=1.
- Command write: on a rising edge with wren=1 to CMD_ADDR, while busy=0 and data[2:0] != 0:
  - latch opcode = data[2:0]; set busy=1; set row=0.
  - Writes while busy=1 are ignored. Opcode 0 is a NOP and does not set busy.
- Opcodes (applied per 16-bit word w):
  - 1 CLEAR: w=0.
  - 2 INVERT: w=~w.
  - 3 INCREMENT: w=w+1 mod 2^16.
  - 4 DOUBLE: w=w<<1, MSB discarded.
  - 5 HALVE: w=w>>1, logical.
  - 6, 7: treated as NOP, but still run the full sweep (busy held for the sweep duration).
- Engine:
  - While busy, each rising edge updates words row*NUM_CORES .. row*NUM_CORES+NUM_CORES-1 in parallel, then row increments.
  - After the last row (MEM_WORDS/NUM_CORES rows, 64 with defaults), busy clears on the same edge.
  - Total busy time = MEM_WORDS/NUM_CORES cycles.
- Host read: on a rising edge with wren=0, the read register captures the addressed byte.
  - data is driven from the read register while wren=0, giving a 1-cycle read latency.
  - Reads during busy return current memory contents (partially processed rows allowed).
- Status read at CMD_ADDR returns {busy, 4'b0, opcode[2:0]}.
- Simultaneous events: a reset assertion mid-sweep aborts the sweep immediately (busy=0, memory cleared).
- Bus turnaround: the block releases data to Z in the same cycle wren rises (combinational enable from wren).

Decomposition:
- Shared package holds:
  - opcode constants (OP_NOP=0, OP_CLEAR=1, OP_INVERT=2, OP_INC=3, OP_DOUBLE=4, OP_HALVE=5);
  - the CMD_ADDR default;
  - the status bit positions.
- One sub-module, videocard_alu_lane: combinational CORE_WIDTH-bit word + opcode -> result. Instantiated NUM_CORES times by generate.
- Top-level holds: memory array, bus interface/decoder, command register, row counter.

Test Plan:
- Byte write/read-back: write byte addr 2k = (2k)%128 and byte addr 2k+1 = 0 for k=0..639; read back -> word 1 = 0x0002, word 63 = 0x007E, word 64 = 0x0000; data is Z while wren=1.
- DOUBLE: after the fill above, write 4 to 0x7FFFFE; busy reads 1; after 64 cycles status = 0x04. Then read word 1 = 0x0004, word 63 = 0x00FC, word 700 = 0x0000.
- Byte-lane isolation: write addr 10 = 0xAB, then addr 11 = 0xCD -> word 5 = 0xCDAB. Rewrite addr 10 = 0x12 -> word 5 = 0xCD12.
- Busy lockout: start INVERT on zeroed memory; write addr 0 = 0x55 and command 3 during busy. Both are ignored; final word 0 = 0xFFFF, opcode still 2.
- Out-of-range and wrap: a write to addr 2048 is ignored and its read returns 0x00. INCREMENT on word 0xFFFF -> 0x0000; HALVE on 0x8001 -> 0x4000.
- Async reset mid-sweep: assert reset 10 cycles after a command -> busy=0 immediately, all memory reads 0x00, status 0x00.
